// File: rtl/branch_predictor_if.sv
// Fetch-lookup and decode-update bundle for branch_predictor.
// The master side (fetch/decode) drives lookups and resolved outcomes; the predictor is the slave.
interface branch_predictor_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 2
);
  logic [PC_W-1:0]  pc_curr;
  logic [CNT_W-1:0] prediction;
  logic             predicted_taken;
  logic [PC_W-1:0]  predicted_target;
  logic             hit;
  logic [PC_W-1:0]  update_pc;
  logic             wen_BHT;
  logic             actual_taken;
  logic             wen_BTB;
  logic [PC_W-1:0]  actual_target;
  logic             update_pred_taken;
  logic [IDX_W-1:0] update_ghr;
  logic [IDX_W-1:0] ghr_out;
  logic [15:0]      branch_cnt;
  logic [15:0]      mispredict_cnt;

  modport master (
    output pc_curr, update_pc, wen_BHT, actual_taken, wen_BTB, actual_target,
           update_pred_taken, update_ghr,
    input  prediction, predicted_taken, predicted_target, hit, ghr_out,
           branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pc_curr, update_pc, wen_BHT, actual_taken, wen_BTB, actual_target,
           update_pred_taken, update_ghr,
    output prediction, predicted_taken, predicted_target, hit, ghr_out,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Tagged BHT + BTB with saturating direction counters and branch/mispredict statistics.
// Define BP_GSHARE_EN to index the counter array with pc index XOR global history.
module branch_predictor #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned TagW    = PC_W - IDX_W - 1;

  localparam logic [CNT_W-1:0] CntWnt = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CntWt  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [15:0]      StatMax = 16'hFFFF;

  logic [Entries-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q    [Entries];
  logic [TagW-1:0]    tag_d    [Entries];
  logic [CNT_W-1:0]   cnt_q    [Entries];
  logic [CNT_W-1:0]   cnt_d    [Entries];
  logic [PC_W-1:0]    target_q [Entries];
  logic [PC_W-1:0]    target_d [Entries];
  logic [15:0]        branch_cnt_q, branch_cnt_d;
  logic [15:0]        mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] l_idx, l_cidx, u_idx, u_cidx;
  logic [TagW-1:0]  l_tag, u_tag;
  logic             l_hit, u_match;
  logic [CNT_W-1:0] l_pred;

  assign l_idx = bus.pc_curr[IDX_W:1];
  assign l_tag = bus.pc_curr[PC_W-1:IDX_W+1];
  assign u_idx = bus.update_pc[IDX_W:1];
  assign u_tag = bus.update_pc[PC_W-1:IDX_W+1];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic             unused_bits;

  assign l_cidx      = l_idx ^ ghr_q;
  assign u_cidx      = u_idx ^ bus.update_ghr;
  assign bus.ghr_out = ghr_q;
  assign ghr_d       = bus.wen_BHT ? ((ghr_q << 1) | IDX_W'(bus.actual_taken)) : ghr_q;
  assign unused_bits = ^{bus.pc_curr[0], bus.update_pc[0]};

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  logic unused_bits;

  assign l_cidx      = l_idx;
  assign u_cidx      = u_idx;
  assign bus.ghr_out = '0;
  assign unused_bits = ^{bus.update_ghr, bus.pc_curr[0], bus.update_pc[0]};
`endif

  // Lookup reads registered state only; same-cycle updates show up next cycle.
  assign l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_pred = l_hit ? cnt_q[l_cidx] : CntWnt;

  assign bus.hit              = l_hit;
  assign bus.prediction       = l_pred;
  assign bus.predicted_taken  = l_hit & l_pred[CNT_W-1];
  assign bus.predicted_target = l_hit ? target_q[l_idx] : '0;
  assign bus.branch_cnt       = branch_cnt_q;
  assign bus.mispredict_cnt   = mispredict_cnt_q;

  assign u_match = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    target_d = target_q;

    if (bus.wen_BHT) begin
      if (u_match) begin
        if (bus.actual_taken) begin
          if (cnt_q[u_cidx] != CntMax) cnt_d[u_cidx] = cnt_q[u_cidx] + CNT_W'(1);
        end else begin
          if (cnt_q[u_cidx] != '0) cnt_d[u_cidx] = cnt_q[u_cidx] - CNT_W'(1);
        end
      end else begin
        cnt_d[u_cidx] = bus.actual_taken ? CntWt : CntWnt;
      end
    end else if (bus.wen_BTB && !u_match) begin
      // A target-only allocation starts weakly taken: the branch was seen taken.
      cnt_d[u_cidx] = CntWt;
    end

    if (bus.wen_BTB) target_d[u_idx] = bus.actual_target;

    if (bus.wen_BHT || bus.wen_BTB) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bus.wen_BHT) begin
      if (branch_cnt_q != StatMax) branch_cnt_d = branch_cnt_q + 16'd1;
      if ((bus.update_pred_taken != bus.actual_taken) && (mispredict_cnt_q != StatMax)) begin
        mispredict_cnt_d = mispredict_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int unsigned i = 0; i < Entries; i++) begin
        tag_q[i]    <= '0;
        cnt_q[i]    <= CntWnt;
        target_q[i] <= '0;
      end
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      cnt_q            <= cnt_d;
      target_q         <= target_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised BHT + BTB for the pipelined CPU. Replaces the fixed untagged 4-bit-indexed predictor inside the fetch stage.
- Fetch looks up the current PC and receives a prediction and a target. Decode writes back resolved outcomes and targets.
- Adds configurable depth, counter width and tag checking, plus saturating performance counters.

Parameters:
- PC_W, 16, PC and target width in bits.
- IDX_W, 3, index bits; ENTRIES = 2**IDX_W.
- CNT_W, 2, saturating-counter width (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- pc_curr  input  PC_W  fetch-stage PC for lookup
- prediction  output  CNT_W  counter value of the looked-up entry
- predicted_taken  output  1  hit & prediction[CNT_W-1]
- predicted_target  output  PC_W  BTB target on hit, else 0
- hit  output  1  looked-up entry valid and tag matches
- update_pc  input  PC_W  PC of the branch resolving in decode
- wen_BHT  input  1  update counter for update_pc
- actual_taken  input  1  resolved direction
- wen_BTB  input  1  write actual_target for update_pc
- actual_target  input  PC_W  resolved target
- update_pred_taken  input  1  predicted_taken carried down the pipe for this branch
- update_ghr  input  IDX_W  GHR snapshot carried down the pipe (used only with macro)
- ghr_out  output  IDX_W  current global history (0 without macro)
- branch_cnt  output  16  resolved branches (saturating)
- mispredict_cnt  output  16  mispredictions (saturating)

Behaviour:
- Addressing:
  - idx = pc[IDX_W:1]; bit 0 is ignored (halfword instructions).
  - tag = pc[PC_W-1:IDX_W+1].
  - Each entry holds valid, tag, counter[CNT_W], target[PC_W].
- Lookup (combinational from registered state):
  - hit = valid[idx] && tag[idx]==tag(pc_curr).
  - prediction = counter[idx] on hit, else WNT.
  - WNT = 2**(CNT_W-1)-1; WT = 2**(CNT_W-1).
  - No bypass: a same-cycle update to the looked-up entry is visible only from the next cycle.
- BHT update (posedge, wen_BHT), entry = idx(update_pc):
  - Tag matches and entry valid: counter +1 if actual_taken, else -1; saturate at 0 and 2**CNT_W-1.
  - Otherwise allocate: valid=1, tag written, counter = WT if actual_taken else WNT, target unchanged.
- BTB update (posedge, wen_BTB): target = actual_target, tag written, valid=1.
  - wen_BTB alone allocating an entry sets counter = WT.
- Both enables on the same entry in the same cycle:
  - Tag/valid written once; target from actual_target.
  - Counter: increment/decrement if the entry already matched, else allocation value per actual_taken.
- Counters:
  - branch_cnt +1 on every wen_BHT.
  - mispredict_cnt +1 when wen_BHT && update_pred_taken != actual_taken.
  - Both hold at 16'hFFFF.
- Reset:
  - All valid=0, counters=WNT, targets=0, ghr=0, branch_cnt=0, mispredict_cnt=0.
  - Resulting outputs: hit=0, prediction=WNT, predicted_taken=0, predicted_target=0.
  - rst wins over any same-cycle write.
- Wrap-around: PCs differing only above bit IDX_W alias to one entry. A tag mismatch yields hit=0 and the next update reallocates the entry.

Optional Feature:
- Macro BP_GSHARE_EN.
- When defined:
  - Global history register ghr[IDX_W] shifts left, inserting actual_taken, on each wen_BHT.
  - BHT counter index for lookup = idx ^ ghr; for update = idx(update_pc) ^ update_ghr.
  - BTB, tag and valid remain indexed by idx alone. The counter array is separate from the tag array.
  - ghr_out = ghr.
- When undefined:
  - Counter index = idx.
  - ghr_out = 0; update_ghr is ignored.

Test Plan:
- Reset, then lookup pc_curr=16'h0004 -> hit=0, prediction=2'b01, predicted_taken=0, predicted_target=16'h0000, counters 0.
- wen_BHT+wen_BTB at update_pc=16'h0004, actual_taken=1, actual_target=16'h0040; next cycle lookup 16'h0004 -> hit=1, prediction=2'b10, predicted_taken=1, predicted_target=16'h0040.
- Three more taken updates on 16'h0004 -> prediction 2'b11 and stays 2'b11. Four not-taken updates -> 2'b10, 2'b01, 2'b00, 2'b00.
- Alias case: entry valid for 16'h0004; lookup 16'h0014 (IDX_W=3, same idx, different tag) -> hit=0. Update 16'h0014 not-taken -> 16'h0004 now misses.
- Same-cycle lookup and update of 16'h0008 -> outputs show the old state that cycle and the new state the next cycle. rst asserted during a wen_BTB -> entry stays invalid.
- 5 updates with update_pred_taken != actual_taken on 2 of them -> branch_cnt=5, mispredict_cnt=2. Preload both counters near 16'hFFFF -> both saturate at 16'hFFFF.
